// File: rtl/fir_pkg.sv
// fir_pkg -- shared helpers for the symmetric FIR filter.
//   clog2()      : ceiling log2 for elaboration-time sizing (clog2(1) = 0)
//   add_st()     : number of registered adder-tree levels for a TAPS-tap filter
//   prod_w()     : width of one folded product (pre-add sum x coefficient)
//   acc_w()      : accumulator width, wide enough that the tree never overflows
//   level_cnt()  : number of live nodes at a given adder-tree level
//   bank_idx_t   : selects one of the two coefficient banks
package fir_pkg;

    localparam int NUM_BANKS = 2;

    typedef logic bank_idx_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    function automatic int add_st(input int taps);
        return clog2(taps / 2);
    endfunction

    function automatic int prod_w(input int data_w, input int coef_w);
        return data_w + 1 + coef_w;
    endfunction

    function automatic int acc_w(input int data_w, input int coef_w, input int taps);
        return prod_w(data_w, coef_w) + add_st(taps);
    endfunction

    // Nodes present after l pairwise reductions of n inputs: ceil(n / 2^l).
    function automatic int level_cnt(input int n, input int l);
        return (n + (1 << l) - 1) >> l;
    endfunction

endpackage

// File: rtl/fir_add_tree.sv
// fir_add_tree -- registered pairwise reduction of N signed inputs.
//   Every level is a register stage; an odd node at the end of a level is
//   forwarded (registered) unchanged.  A valid bit travels beside the data.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   in_valid    : in_data carries a real sample this cycle
//   in_data     : N signed operands, IN_W bits each
//   out_valid   : out_data is the sum of an input set, ADD_ST cycles later
//   out_data    : signed sum, IN_W + ADD_ST bits (cannot overflow)
module fir_add_tree
    import fir_pkg::*;
#(
    parameter  int N      = 20,
    parameter  int IN_W   = 52,
    localparam int ADD_ST = clog2(N),
    localparam int OUT_W  = IN_W + ADD_ST
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    input  logic signed [IN_W-1:0]  in_data [N],
    output logic                    out_valid,
    output logic signed [OUT_W-1:0] out_data
);

    // lvl_q[l] holds the result of reduction level l+1.
    logic signed [OUT_W-1:0] lvl_q [ADD_ST][N];
    logic signed [OUT_W-1:0] lvl_d [ADD_ST][N];
    logic [ADD_ST-1:0]       vld_q;
    logic [ADD_ST-1:0]       vld_d;

    always_comb begin
        logic signed [OUT_W-1:0] src [N];
        int a_idx;
        int b_idx;
        lvl_d = '{default: '0};
        vld_d = '0;
        for (int l = 0; l < ADD_ST; l++) begin
            for (int i = 0; i < N; i++) begin
                src[i] = (l == 0) ? OUT_W'(in_data[i]) : lvl_q[(l == 0) ? 0 : l - 1][i];
            end
            vld_d[l] = (l == 0) ? in_valid : vld_q[(l == 0) ? 0 : l - 1];
            for (int i = 0; i < N; i++) begin
                // Clamp the indices so the unused branches never reach past N.
                a_idx = (2 * i < N) ? 2 * i : 0;
                b_idx = (2 * i + 1 < N) ? 2 * i + 1 : 0;
                if (2 * i + 1 < level_cnt(N, l)) begin
                    lvl_d[l][i] = src[a_idx] + src[b_idx];
                end else if (2 * i < level_cnt(N, l)) begin
                    lvl_d[l][i] = src[a_idx];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lvl_q <= '{default: '0};
            vld_q <= '0;
        end else begin
            lvl_q <= lvl_d;
            vld_q <= vld_d;
        end
    end

    assign out_data  = lvl_q[ADD_ST-1][0];
    assign out_valid = vld_q[ADD_ST-1];

endmodule

// File: rtl/fir_sym_pipe.sv
// fir_sym_pipe -- TAPS-tap linear-phase FIR with folded pre-add (TAPS/2
// multipliers), registered adder tree, round-half-up output shift and
// double-buffered runtime-reloadable coefficients.
// Build option: define FIR_SAT_EN to clamp the output to DATA_W bits;
// otherwise the output wraps (low DATA_W bits of the rounded result).
// Ports:
//   m_clk, rst_n      : clock, asynchronous active-low reset
//   in_valid, data_in : sample input, accepted whenever in_valid is high
//   coef_we/addr/wdata: write coefficient k (h[k] = h[TAPS-1-k]) to shadow bank
//   coef_commit       : swap shadow and active banks
//   coef_busy         : high for 2 cycles after a commit; writes/commits ignored
//   out_valid/data_out: one-cycle pulse per accepted sample, LAT = 4+ADD_ST later
// Handshake: no backpressure.  in_valid high means data_in is consumed at that
// rising edge; out_valid is a single-cycle pulse and data_out holds between pulses.
module fir_sym_pipe
    import fir_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int COEF_W    = 19,
    parameter int TAPS      = 40,
    parameter int OUT_SHIFT = 18
) (
    input  logic                        m_clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    input  logic signed [DATA_W-1:0]    data_in,
    input  logic                        coef_we,
    input  logic [clog2(TAPS/2)-1:0]    coef_addr,
    input  logic signed [COEF_W-1:0]    coef_wdata,
    input  logic                        coef_commit,
    output logic                        coef_busy,
    output logic                        out_valid,
    output logic signed [DATA_W-1:0]    data_out
);

    localparam int HALF   = TAPS / 2;
    localparam int PRE_W  = DATA_W + 1;
    localparam int PROD_W = prod_w(DATA_W, COEF_W);
    localparam int ACC_W  = acc_w(DATA_W, COEF_W, TAPS);

    localparam logic signed [ACC_W:0] RND =
        (OUT_SHIFT == 0) ? '0 : ((ACC_W+1)'(1) << ((OUT_SHIFT > 0) ? OUT_SHIFT - 1 : 0));
    localparam logic signed [ACC_W:0] SAT_MAX = {{(ACC_W + 2 - DATA_W){1'b0}}, {(DATA_W - 1){1'b1}}};
    localparam logic signed [ACC_W:0] SAT_MIN = ~SAT_MAX;

    logic signed [DATA_W-1:0] x_q     [TAPS];
    logic signed [DATA_W-1:0] x_d     [TAPS];
    logic signed [PRE_W-1:0]  p_q     [HALF];
    logic signed [PRE_W-1:0]  p_d     [HALF];
    logic signed [PROD_W-1:0] m_q     [HALF];
    logic signed [PROD_W-1:0] m_d     [HALF];
    logic signed [COEF_W-1:0] coef_q  [NUM_BANKS][HALF];
    logic signed [COEF_W-1:0] coef_d  [NUM_BANKS][HALF];

    logic        v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
    bank_idx_t   tag1_q, tag1_d, tag2_q, tag2_d;
    bank_idx_t   active_q, active_d;
    logic [1:0]  busy_cnt_q, busy_cnt_d;
    logic        out_valid_q, out_valid_d;
    logic signed [DATA_W-1:0] data_out_q, data_out_d;

    logic                     commit_ok;
    logic                     we_ok;
    logic                     tree_valid;
    logic signed [ACC_W-1:0]  tree_sum;
    logic signed [ACC_W:0]    rounded;
    logic signed [ACC_W:0]    shifted;
    logic signed [DATA_W-1:0] result;

    assign coef_busy = (busy_cnt_q != 2'd0);

    // Coefficient banks, delay line, pre-add and multiply stages.
    always_comb begin
        commit_ok = coef_commit && !coef_busy;
        we_ok     = coef_we && !coef_busy && (int'(coef_addr) < HALF);

        // A write in the commit cycle lands in the old shadow, which becomes active.
        coef_d = coef_q;
        if (we_ok) begin
            coef_d[~active_q][coef_addr] = coef_wdata;
        end
        active_d = active_q ^ commit_ok;

        // busy covers the two cycles in which samples tagged with the old bank
        // can still reach the multiplier, so the old bank is not overwritten.
        if (commit_ok) begin
            busy_cnt_d = 2'd2;
        end else if (coef_busy) begin
            busy_cnt_d = busy_cnt_q - 2'd1;
        end else begin
            busy_cnt_d = 2'd0;
        end

        x_d = x_q;
        if (in_valid) begin
            x_d[0] = data_in;
            for (int i = 1; i < TAPS; i++) begin
                x_d[i] = x_q[i-1];
            end
        end
        v1_d   = in_valid;
        tag1_d = active_d;   // sample accepted in the commit cycle uses the new bank

        for (int k = 0; k < HALF; k++) begin
            p_d[k] = PRE_W'(x_q[k]) + PRE_W'(x_q[TAPS-1-k]);
        end
        v2_d   = v1_q;
        tag2_d = tag1_q;

        for (int k = 0; k < HALF; k++) begin
            m_d[k] = PROD_W'(coef_q[tag2_q][k]) * PROD_W'(p_q[k]);
        end
        v3_d = v2_q;
    end

    fir_add_tree #(
        .N    (HALF),
        .IN_W (PROD_W)
    ) u_add_tree (
        .clk       (m_clk),
        .rst_n     (rst_n),
        .in_valid  (v3_q),
        .in_data   (m_q),
        .out_valid (tree_valid),
        .out_data  (tree_sum)
    );

    // Output stage: round half up, arithmetic shift, then clamp or wrap.
    always_comb begin
        rounded = (ACC_W+1)'(tree_sum) + RND;
        shifted = rounded >>> OUT_SHIFT;
`ifdef FIR_SAT_EN
        if (shifted > SAT_MAX) begin
            result = SAT_MAX[DATA_W-1:0];
        end else if (shifted < SAT_MIN) begin
            result = SAT_MIN[DATA_W-1:0];
        end else begin
            result = shifted[DATA_W-1:0];
        end
`else
        result = shifted[DATA_W-1:0];
`endif
        out_valid_d = tree_valid;
        data_out_d  = tree_valid ? result : data_out_q;
    end

    always_ff @(posedge m_clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q         <= '{default: '0};
            p_q         <= '{default: '0};
            m_q         <= '{default: '0};
            coef_q      <= '{default: '0};
            v1_q        <= 1'b0;
            v2_q        <= 1'b0;
            v3_q        <= 1'b0;
            tag1_q      <= 1'b0;
            tag2_q      <= 1'b0;
            active_q    <= 1'b0;
            busy_cnt_q  <= 2'd0;
            out_valid_q <= 1'b0;
            data_out_q  <= '0;
        end else begin
            x_q         <= x_d;
            p_q         <= p_d;
            m_q         <= m_d;
            coef_q      <= coef_d;
            v1_q        <= v1_d;
            v2_q        <= v2_d;
            v3_q        <= v3_d;
            tag1_q      <= tag1_d;
            tag2_q      <= tag2_d;
            active_q    <= active_d;
            busy_cnt_q  <= busy_cnt_d;
            out_valid_q <= out_valid_d;
            data_out_q  <= data_out_d;
        end
    end

    assign out_valid = out_valid_q;
    assign data_out  = data_out_q;

endmodule

// File: tb/tb_fir_sym_pipe.sv
// tb_fir_sym_pipe -- self-checking bench for fir_sym_pipe at default parameters.
// Expected outputs come from a direct-form convolution over the full history of
// accepted samples, using the coefficient bank selected when each sample was taken.
// Define FIR_SAT_EN for both bench and RTL to exercise the clamping build.
module tb_fir_sym_pipe;

    localparam int DATA_W = 32;
    localparam int COEF_W = 19;
    localparam int TAPS   = 40;
    localparam int HALF   = 20;
    localparam int LAT    = 9;

    // ---------------- clock / reset ----------------
    logic m_clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 m_clk = ~m_clk;

    int cyc = 0;
    always @(posedge m_clk) cyc <= cyc + 1;

    logic              in_valid = 1'b0;
    logic [DATA_W-1:0] data_in = '0;
    logic              coef_we = 1'b0;
    logic [4:0]        coef_addr = '0;
    logic [COEF_W-1:0] coef_wdata = '0;
    logic              coef_commit = 1'b0;
    logic              coef_busy;
    logic              out_valid;
    logic [DATA_W-1:0] data_out;

    fir_sym_pipe dut (
        .m_clk       (m_clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .data_in     (data_in),
        .coef_we     (coef_we),
        .coef_addr   (coef_addr),
        .coef_wdata  (coef_wdata),
        .coef_commit (coef_commit),
        .coef_busy   (coef_busy),
        .out_valid   (out_valid),
        .data_out    (data_out)
    );

    // ---------------- scoreboard / reference model ----------------
    int tests = 0;
    int fails = 0;

    logic [DATA_W-1:0] exp_q[$];
    int                due_q[$];
    int                hist[$];
    int                mc [2][HALF];
    int                m_act = 0;
    int                m_busy = 0;
    logic [DATA_W-1:0] last_out = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // y[n] = sum_j h[j] * x[n-j], h[j] = c[min(j, TAPS-1-j)], then round and shift.
    function automatic logic [DATA_W-1:0] model_out(input int bank);
        longint acc;
        longint r;
        int     k;
        int     xi;
        acc = 0;
        for (int j = 0; j < TAPS; j++) begin
            k  = (j < HALF) ? j : TAPS - 1 - j;
            xi = hist.size() - 1 - j;
            if (xi >= 0) acc += longint'(mc[bank][k]) * longint'(hist[xi]);
        end
        r = (acc + (longint'(1) <<< 17)) >>> 18;
`ifdef FIR_SAT_EN
        if (r > 64'sd2147483647) r = 64'sd2147483647;
        if (r < -64'sd2147483648) r = -64'sd2147483648;
`endif
        return r[DATA_W-1:0];
    endfunction

    task automatic model_edge(input logic v, input logic [DATA_W-1:0] d, input logic we,
                              input logic [4:0] a, input logic [COEF_W-1:0] wd, input logic cm);
        bit busy;
        busy = (m_busy > 0);
        if (we && !busy) mc[1-m_act][a] = int'($signed(wd));
        if (cm && !busy) begin
            m_act  = 1 - m_act;
            m_busy = 2;
        end else if (m_busy > 0) begin
            m_busy--;
        end
        if (v) begin
            hist.push_back(int'($signed(d)));
            exp_q.push_back(model_out(m_act));
            // Sampled at edge e, out_valid is driven by edge e+LAT-1; the bench
            // cycle counter reads e+1 here and e+LAT at that output.
            due_q.push_back(cyc + LAT - 1);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        exp_q.delete();
        due_q.delete();
        mc       = '{default: 0};
        m_act    = 0;
        m_busy   = 0;
        last_out = '0;
    endtask

    // ---------------- monitor ----------------
    always @(negedge m_clk) begin
        logic [DATA_W-1:0] e;
        int                d;
        if (rst_n) begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_out_valid", 64'(out_valid), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    d = due_q.pop_front();
                    chk("latency", 64'(cyc), 64'(d));
                    chk("data_out", 64'(data_out), 64'(e));
                    last_out = e;
                end
            end else begin
                chk("data_out_hold", 64'(data_out), 64'(last_out));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input logic v, input logic [DATA_W-1:0] d, input logic we,
                         input logic [4:0] a, input logic [COEF_W-1:0] wd, input logic cm);
        in_valid    = v;
        data_in     = d;
        coef_we     = we;
        coef_addr   = a;
        coef_wdata  = wd;
        coef_commit = cm;
        @(negedge m_clk);
        if (rst_n) begin
            model_edge(v, d, we, a, wd, cm);
            chk("coef_busy", 64'(coef_busy), 64'(m_busy > 0));
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, '0, 1'b0, '0, '0, 1'b0);
    endtask

    task automatic wr(input int a, input int val);
        drive(1'b0, '0, 1'b1, 5'(a), COEF_W'(val), 1'b0);
    endtask

    task automatic commit_banks();
        drive(1'b0, '0, 1'b0, '0, '0, 1'b1);
        idle(2);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 3 * LAT) begin
            idle(1);
            n++;
        end
        chk("drain_pending", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        due_q.delete();
    endtask

    task automatic impulse(input int gap);
        for (int n = 0; n < TAPS; n++) begin
            drive(1'b1, (n == 0) ? 32'd262144 : 32'd0, 1'b0, '0, '0, 1'b0);
            idle(gap);
        end
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        // reset state
        idle(2);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_data_out", 64'(data_out), 64'd0);
        chk("rst_coef_busy", 64'(coef_busy), 64'd0);
        rst_n = 1'b1;
        idle(1);

        // impulse with c[k] = k+1: expect 1..20,20..1
        for (int k = 0; k < HALF; k++) wr(k, k + 1);
        commit_banks();
        impulse(0);
        drain();

        // same impulse, sample every 3rd cycle
        impulse(2);
        drain();

        // saturation / wrap: c[0] = 262143 on a full-scale positive input
        wr(0, 262143);
        commit_banks();
        for (int n = 0; n < 50; n++) drive(1'b1, 32'h7FFF_FFFF, 1'b0, '0, '0, 1'b0);
        drain();

        // bank swap: active c[0]=1, shadow c[0]=2, commit mid-stream
        for (int k = 0; k < HALF; k++) wr(k, (k == 0) ? 1 : 0);
        commit_banks();
        wr(0, 2);
        for (int n = 0; n < 45; n++) drive(1'b1, 32'd262144, 1'b0, '0, '0, 1'b0);
        drive(1'b1, 32'd262144, 1'b0, '0, '0, 1'b1);
        drive(1'b1, 32'd262144, 1'b1, 5'd0, 19'd7, 1'b0);   // dropped while busy
        drive(1'b1, 32'd262144, 1'b1, 5'd0, 19'd7, 1'b1);   // write and commit both ignored
        for (int n = 0; n < 45; n++) drive(1'b1, 32'd262144, 1'b0, '0, '0, 1'b0);
        drive(1'b1, 32'd262144, 1'b0, '0, '0, 1'b1);         // shadow still holds c[0]=1
        for (int n = 0; n < 45; n++) drive(1'b1, 32'd262144, 1'b0, '0, '0, 1'b0);
        drain();

        // random samples, gaps, coefficient writes and commits
        for (int n = 0; n < 600; n++) begin
            drive($urandom_range(0, 3) != 0, $urandom(),
                  $urandom_range(0, 7) == 0, 5'($urandom_range(0, HALF - 1)),
                  COEF_W'($urandom_range(0, (1 << COEF_W) - 1)),
                  $urandom_range(0, 29) == 0);
        end
        drain();

        // reset in the middle of an impulse response
        impulse(0);
        idle(4);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_data_out", 64'(data_out), 64'd0);
        chk("midrst_coef_busy", 64'(coef_busy), 64'd0);
        model_reset();
        idle(2);
        rst_n = 1'b1;
        for (int n = 0; n < 50; n++) drive(1'b1, 32'd0, 1'b0, '0, '0, 1'b0);
        impulse(0);
        drain();

        chk("final_queue_empty", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/fir_sym_pipe.md
# fir_sym_pipe

Parametrised symmetric-coefficient FIR filter: TAPS-tap linear-phase filter, folded pre-add so only TAPS/2 multipliers, fully registered adder tree, rounding and optional saturation on output. Successor of the fixed 40-tap filter: generic width/depth, runtime-reloadable double-buffered coefficients, and a valid flag that tracks each sample through the pipeline instead of a fixed enable delay. Sits in the sample-processing chain between the input sample source and downstream scaling/display logic.

## Interface
- DATA_W, 32, signed input/output sample width
- COEF_W, 19, signed coefficient width
- TAPS, 40, filter length; even, ≥4
- OUT_SHIFT, 18, arithmetic right shift applied to accumulator before output
- m_clk  in  1  system clock, all logic rising-edge
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- in_valid  in  1  data_in accepted this cycle
- data_in  in  DATA_W  signed sample
- coef_we  in  1  write shadow coefficient
- coef_addr  in  clog2(TAPS/2)  coefficient index k (0..TAPS/2-1); h[k]=h[TAPS-1-k]
- coef_wdata  in  COEF_W  signed coefficient
- coef_commit  in  1  swap shadow/active banks
- coef_busy  out  1  writes ignored this cycle
- out_valid  out  1  data_out valid, one-cycle pulse per input sample
- data_out  out  DATA_W  signed filtered sample

## Operation
- Delay line x[0..TAPS-1], DATA_W each; shifts only on in_valid (x[0]<=data_in). No shift otherwise.
- Pre-add: p[k]=x[k]+x[TAPS-1-k], DATA_W+1 bits, k=0..TAPS/2-1.
- Multiply: m[k]=c[bank][k]*p[k], DATA_W+1+COEF_W bits.
- Adder tree: ADD_ST=clog2(TAPS/2) registered levels, pairwise; odd element passes through registered. ACC_W=DATA_W+COEF_W+1+ADD_ST (57 at defaults); no internal overflow possible.
- Output: r=(acc + 2^(OUT_SHIFT-1)) >>> OUT_SHIFT (round half up; OUT_SHIFT=0 → no rounding term); then saturate/wrap to DATA_W (see Configuration).
- Coefficients: two banks of TAPS/2 entries. coef_we writes shadow bank (the one not active). coef_commit toggles active bank. Each accepted sample carries a 1-bit bank tag captured at acceptance; multiply stage uses bank[tag]. Sample accepted in the commit cycle uses the new bank.
- coef_busy high for the 2 cycles following a commit; coef_we during busy is dropped. coef_commit during busy is ignored. coef_we and coef_commit in same non-busy cycle: write lands in old shadow (becomes active), then swap.
- Valid bit per stage; stages advance every cycle; bubbles propagate as invalid. Data registers of invalid stages hold don't-care but must not affect later valid results.
- Reset: delay line, all pipeline regs, both coefficient banks = 0; active bank = 0; coef_busy=0, out_valid=0, data_out=0. Reset mid-stream discards all in-flight samples; no out_valid until new samples traverse pipeline.

## Timing
- Stages: delay line (1), pre-add (1), multiply (1), adder tree (ADD_ST), output (1). Latency LAT=4+ADD_ST cycles from in_valid edge to out_valid; 9 at defaults.
- Throughput: one sample per cycle; arbitrary gaps allowed; output sequence independent of gap pattern.
- data_out holds last value while out_valid=0.
- coef_busy asserts the cycle after commit is sampled, deasserts 2 cycles later.

## Configuration
- FIR_SAT_EN defined: r outside [-2^(DATA_W-1), 2^(DATA_W-1)-1] clamps to nearest bound.
- FIR_SAT_EN undefined: low DATA_W bits of r taken (two's-complement wrap); no saturation logic.

## Structure
- Package fir_pkg: clog2 function, ACC_W/PROD_W derivation functions, coefficient bank index type.
- Sub-module fir_add_tree (parameters N, IN_W; registered pairwise reduction with valid pipeline, ADD_ST levels). Delay line, pre-add, multiply, coefficient banks and output stage stay in top.

## Test plan
- Impulse: write c[k]=k+1, k=0..19, commit; feed 2^18 then 39 zeros continuous → 40 outputs 1,2,…,20,20,…,1; first out_valid exactly 9 cycles after impulse.
- Gapped input: same stimulus with in_valid every 3rd cycle → identical 40-value sequence, each out_valid 9 cycles after its input.
- Saturation: c[0]=262143, others 0; data_in=0x7FFFFFFF continuous → with FIR_SAT_EN, steady output 0x7FFFFFFF; without, low 32 bits of rounded result.
- Bank swap: active c[0]=1, shadow c[0]=2, commit mid-stream of constant 2^18 input → samples before commit give 2, from commit cycle onward 4 (after window fills); coef_we in the 2 busy cycles has no effect.
- Reset mid-stream: assert rst_n low during impulse response → out_valid=0, data_out=0 immediately; after release, zeros-only input gives zero output, coefficients read back as zero (impulse yields all-zero).
